// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues sequential 1-cycle-latency fetches,
// and buffers returned words with their PCs in a small circular queue feeding decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] PC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [63:0] dec_pc,
    input  logic        dec_ready,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

    state_t        state;
    logic [63:0]   pc;
    logic [63:0]   req_pc;
    logic [AW:0]   occ;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          inflight;
    logic          squash;

    logic [31:0]   inst_mem [DEPTH];
    logic [63:0]   pc_mem   [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;
    logic          flush;
    logic [AW+1:0] credit_used;

    // An outstanding fetch reserves a slot so the response can never land on a full queue.
    assign credit_used = {1'b0, occ} + (AW+2)'(inflight);
    assign issue       = (state == RUN) && !halt_req && !redirect &&
                         (credit_used < (AW+2)'(DEPTH));
    assign flush       = redirect && (state != BOOT);
    assign push        = imem_rvalid && !squash;
    assign pop         = dec_valid && dec_ready;

    assign imem_req  = issue;
    assign imem_addr = pc;
    assign dec_valid = (occ != '0);
    assign dec_inst  = dec_valid ? inst_mem[head] : 32'h0;
    assign dec_pc    = dec_valid ? pc_mem[head]   : 64'h0;
    assign halted    = (state == HALTED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= BOOT;
            pc       <= PC_RESET & ~64'd3;
            req_pc   <= 64'h0;
            occ      <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
            squash   <= 1'b0;
        end else begin
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (halt_req && occ == '0 && !inflight && !redirect) state <= HALTED;
                HALTED:  if (redirect && !halt_req) state <= RUN;
                default: state <= BOOT;
            endcase

            inflight <= issue;
            if (issue) begin
                pc     <= pc + 64'd4;
                req_pc <= pc;
            end

            // Redirect wins over any push/pop in the same cycle: the whole queue is discarded.
            if (flush) begin
                occ    <= '0;
                head   <= '0;
                tail   <= '0;
                pc     <= redirect_pc & ~64'd3;
                squash <= inflight;
            end else begin
                squash <= 1'b0;
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            inst_mem[tail] <= imem_rdata;
            pc_mem[tail]   <= req_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue with a 1-cycle instruction memory that returns PC>>2.
module tb_fetch_queue;
    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [63:0] dec_pc;
    logic        dec_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        halt_req;
    logic        halted;

    int total = 0;
    int bad   = 0;

    fetch_queue #(.DEPTH(4), .PC_RESET(64'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .dec_valid  (dec_valid),
        .dec_inst   (dec_inst),
        .dec_pc     (dec_pc),
        .dec_ready  (dec_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt_req   (halt_req),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: a request seen in one cycle is answered during the next one.
    logic        pend_req  = 1'b0;
    logic [63:0] pend_addr = 64'h0;
    always @(negedge clk) begin
        pend_req  = imem_req;
        pend_addr = imem_addr;
        if (rst && imem_rvalid && !dut.squash) begin
            total++;
            if (dut.occ == 3'd4) begin
                bad++;
                $display("FAIL overflow: write while full, occ=%0d required<4", dut.occ);
            end
        end
    end
    always begin
        @(posedge clk);
        #1;
        imem_rvalid = pend_req;
        imem_rdata  = pend_req ? pend_addr[33:2] : 32'h0;
    end

    typedef struct {
        logic        ready;
        logic        redir;
        logic [63:0] rpc;
        logic        halt;
        logic        req;
        logic [63:0] addr;
        logic        valid;
        logic [63:0] pc;
        logic        hlt;
    } vec_t;

    localparam int NV = 45;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic ready, input logic redir, input logic [63:0] rpc,
                                input logic halt, input logic req, input logic [63:0] addr,
                                input logic valid, input logic [63:0] pc, input logic hlt);
        vec_t v;
        v.ready = ready; v.redir = redir; v.rpc = rpc; v.halt = halt;
        v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.hlt = hlt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cycle(input int idx, input logic req, input logic [63:0] addr,
                               input logic valid, input logic [63:0] pc, input logic hlt);
        check($sformatf("req[%0d]", idx), 64'(imem_req), 64'(req));
        check($sformatf("valid[%0d]", idx), 64'(dec_valid), 64'(valid));
        check($sformatf("halted[%0d]", idx), 64'(halted), 64'(hlt));
        if (req)   check($sformatf("addr[%0d]", idx), imem_addr, addr);
        if (valid) begin
            check($sformatf("pc[%0d]", idx), dec_pc, pc);
            check($sformatf("inst[%0d]", idx), 64'(dec_inst), 64'(pc[33:2]));
        end
        $display("cycle %0d: req=%0b addr=%0h valid=%0b pc=%0h halted=%0b",
                 idx, imem_req, imem_addr, dec_valid, dec_pc, halted);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},    64'(imem_req),  64'h0);
        check({tag, "_valid"},  64'(dec_valid), 64'h0);
        check({tag, "_inst"},   64'(dec_inst),  64'h0);
        check({tag, "_pc"},     dec_pc,         64'h0);
        check({tag, "_halted"}, 64'(halted),    64'h0);
    endtask

    initial begin
        // Startup stream, backpressure, redirects, halt/resume; one row per cycle after reset release.
        vecs[0] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 2; k++)  vecs[k] = mk(1, 0, 0, 0, 1, 64'((k-1)*4), 0, 0, 0);
        for (int k = 3; k <= 5; k++)  vecs[k] = mk(1, 0, 0, 0, 1, 64'((k-1)*4), 1, 64'((k-3)*4), 0);
        vecs[6] = mk(0, 0, 0, 0, 1, 64'd20, 1, 64'd12, 0);
        vecs[7] = mk(0, 0, 0, 0, 1, 64'd24, 1, 64'd12, 0);
        for (int k = 8; k <= 15; k++) vecs[k] = mk(0, 0, 0, 0, 0, 0, 1, 64'd12, 0);
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 1, 64'd12, 0);
        for (int k = 17; k <= 21; k++)
            vecs[k] = mk(1, 0, 0, 0, 1, 64'(28 + (k-17)*4), 1, 64'(16 + (k-17)*4), 0);
        vecs[22] = mk(1, 1, 64'h1003, 0, 0, 0, 1, 64'd36, 0);
        vecs[23] = mk(1, 0, 0, 0, 1, 64'h1000, 0, 0, 0);
        vecs[24] = mk(1, 0, 0, 0, 1, 64'h1004, 0, 0, 0);
        vecs[25] = mk(1, 0, 0, 0, 1, 64'h1008, 1, 64'h1000, 0);
        vecs[26] = mk(1, 0, 0, 0, 1, 64'h100c, 1, 64'h1004, 0);
        vecs[27] = mk(1, 1, 64'h3000, 0, 0, 0, 1, 64'h1008, 0);
        vecs[28] = mk(1, 1, 64'h2000, 0, 0, 0, 0, 0, 0);
        vecs[29] = mk(1, 0, 0, 0, 1, 64'h2000, 0, 0, 0);
        vecs[30] = mk(1, 0, 0, 0, 1, 64'h2004, 0, 0, 0);
        vecs[31] = mk(1, 0, 0, 0, 1, 64'h2008, 1, 64'h2000, 0);
        vecs[32] = mk(1, 0, 0, 0, 1, 64'h200c, 1, 64'h2004, 0);
        vecs[33] = mk(0, 0, 0, 0, 1, 64'h2010, 1, 64'h2008, 0);
        vecs[34] = mk(0, 0, 0, 1, 0, 0, 1, 64'h2008, 0);
        vecs[35] = mk(0, 0, 0, 1, 0, 0, 1, 64'h2008, 0);
        vecs[36] = mk(1, 0, 0, 1, 0, 0, 1, 64'h2008, 0);
        vecs[37] = mk(1, 0, 0, 1, 0, 0, 1, 64'h200c, 0);
        vecs[38] = mk(1, 0, 0, 1, 0, 0, 1, 64'h2010, 0);
        vecs[39] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0);
        vecs[40] = mk(1, 0, 0, 1, 0, 0, 0, 0, 1);
        vecs[41] = mk(1, 1, 64'h40, 0, 0, 0, 0, 0, 1);
        vecs[42] = mk(1, 0, 0, 0, 1, 64'h40, 0, 0, 0);
        vecs[43] = mk(1, 0, 0, 0, 1, 64'h44, 0, 0, 0);
        vecs[44] = mk(1, 0, 0, 0, 1, 64'h48, 1, 64'h40, 0);

        rst = 1'b0; dec_ready = 1'b1; redirect = 1'b0; redirect_pc = 64'h0; halt_req = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            dec_ready   = vecs[i].ready;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            halt_req    = vecs[i].halt;
            @(negedge clk);
            check_cycle(i, vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].pc, vecs[i].hlt);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a live stream.
        redirect = 1'b0; halt_req = 1'b0; dec_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        // A redirect while still in BOOT must be ignored.
        redirect = 1'b1; redirect_pc = 64'h500;
        @(negedge clk);
        check_cycle(100, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            check_cycle(100 + k, 1'b1, 64'((k-1)*4), (k >= 3), 64'(k >= 3 ? (k-3)*4 : 0), 1'b0);
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
